// File: rtl/wallace_pipe_mult.sv
// wallace_pipe_mult: 3-stage valid/ready Wallace-tree multiplier with per-transaction signed/unsigned mode
module wallace_pipe_mult #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic             out_signed
);
  localparam int N = WIDTH + 1;
  localparam int NR = N + 1;
  localparam int LV = 10;
  logic v1, v2, v3, s1, s2, s3;
  logic [WIDTH-1:0] a1, b1;
  logic [OUT_W-1:0] r2_s, r2_c, p3;
  logic [N-1:0] ae, be;
  logic [OUT_W-1:0] cur [NR];
  logic [OUT_W-1:0] nxt [NR];
  logic [OUT_W-1:0] x, y, z;
  int n, k;
  logic go1, go3;
  assign go3 = !v3 || out_ready;
  assign go1 = !v2 || go3;
  assign in_ready = !v1 || go1;
  assign out_valid = v3;
  assign out_p = p3;
  assign out_signed = s3;
  // Operands are extended by one bit (sign or zero) so a single (WIDTH+1)-bit Baugh-Wooley array serves both modes; rows are then reduced 3:2 per layer until two remain
  always_comb begin
    ae = {s1 & a1[WIDTH-1], a1};
    be = {s1 & b1[WIDTH-1], b1};
    x = '0;
    y = '0;
    z = '0;
    for (int i = 0; i < NR; i++) cur[i] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i + j < OUT_W) cur[i][i + j] = (ae[j] & be[i]) ^ ((i == N - 1) != (j == N - 1));
    cur[N][N] = 1'b1;
    n = NR;
    for (int l = 0; l < LV; l++) begin
      k = 0;
      for (int i = 0; i < NR; i++) nxt[i] = '0;
      for (int g = 0; g < NR / 3; g++)
        if (g < n / 3) begin
          x = cur[3 * g];
          y = cur[3 * g + 1];
          z = cur[3 * g + 2];
          nxt[k] = x ^ y ^ z;
          nxt[k + 1] = ((x & y) | (x & z) | (y & z)) << 1;
          k = k + 2;
        end
      for (int t = 0; t < 2; t++)
        if (t < n % 3) nxt[k + t] = cur[3 * (n / 3) + t];
      n = k + n % 3;
      cur = nxt;
    end
  end
  // Bubble-collapsing pipeline: valids move when the downstream stage frees up, data loads only with a valid entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      s1 <= 1'b0;
      r2_s <= '0;
      r2_c <= '0;
      s2 <= 1'b0;
      p3 <= '0;
      s3 <= 1'b0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_ready && in_valid) begin
        a1 <= in_a;
        b1 <= in_b;
        s1 <= in_signed;
      end
      if (go1) v2 <= v1;
      if (go1 && v1) begin
        r2_s <= cur[0];
        r2_c <= cur[1];
        s2 <= s1;
      end
      if (go3) v3 <= v2;
      if (go3 && v2) begin
        p3 <= r2_s + r2_c;
        s3 <= s2;
      end
    end
endmodule

// File: tb/tb_wallace_pipe_mult.sv
// tb_wallace_pipe_mult: table-driven and randomised scoreboard bench for wallace_pipe_mult
module tb_wallace_pipe_mult;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rnd_go = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;
  typedef struct {
    logic [15:0] p;
    logic        s;
    int          acc;
    logic        lat;
  } exp_t;
  vec_t tbl[9];
  exp_t q[$];
  exp_t e_m;
  logic iv, ir, s, ov, ordy, os, lat_on;
  logic [7:0] a, b;
  logic [15:0] p, cur_exp;
  wallace_pipe_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b), .in_signed(s),
    .out_valid(ov), .out_ready(ordy), .out_p(p), .out_signed(os)
  );
  always @(negedge clk)
    if (!rst) begin
      if (ov && ordy) begin
        if (q.size() == 0) chk("spurious_output", 64'(ov), 64'(0));
        else begin
          e_m = q.pop_front();
          chk("out_p", 64'(p), 64'(e_m.p));
          chk("out_signed", 64'(os), 64'(e_m.s));
          if (e_m.lat) chk("latency_edges", 64'(cyc - e_m.acc), 64'(2));
        end
      end
      if (iv && ir) q.push_back('{p: cur_exp, s: s, acc: cyc + 1, lat: lat_on});
    end
  task automatic send(input vec_t v);
    int t;
    iv = 1'b1;
    a = v.a;
    b = v.b;
    s = v.s;
    cur_exp = v.p;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (ir) break;
      t++;
    end
    chk("send_accept_timeout", 64'(t < 50), 64'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || ov) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t < 200), 64'(1));
    @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 4; g++) begin : rnd
    localparam int W = g == 0 ? 4 : g == 1 ? 8 : g == 2 ? 13 : 32;
    logic riv, rir, rs, rov, rordy, ros, acc_last, fin;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rp;
    logic [2*W:0] rq[$];
    logic [2*W:0] e;
    int nin, nout;
    wallace_pipe_mult #(.WIDTH(W)) dut_r (
      .clk(clk), .rst(rst), .in_valid(riv), .in_ready(rir), .in_a(ra), .in_b(rb), .in_signed(rs),
      .out_valid(rov), .out_ready(rordy), .out_p(rp), .out_signed(ros)
    );
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg);
      logic [65:0] ex, ey, pr;
      ex = {{(66 - W){sg & x[W-1]}}, x};
      ey = {{(66 - W){sg & y[W-1]}}, y};
      pr = ex * ey;
      return pr[2*W-1:0];
    endfunction
    function automatic logic [W-1:0] pick();
      int c;
      c = $urandom_range(0, 7);
      return c == 0 ? {1'b1, {(W - 1){1'b0}}} : c == 1 ? {W{1'b1}} : c == 2 ? {1'b0, {(W - 1){1'b1}}} : W'($urandom);
    endfunction
    always @(negedge clk)
      if (!rst && rnd_go) begin
        if (rov && rordy) begin
          if (rq.size() == 0) chk($sformatf("rnd%0d_spurious", W), 64'(rov), 64'(0));
          else begin
            e = rq.pop_front();
            chk($sformatf("rnd%0d_p", W), 64'(rp), 64'(e[2*W-1:0]));
            chk($sformatf("rnd%0d_signed", W), 64'(ros), 64'(e[2*W]));
          end
          nout++;
        end
        if (riv && rir) begin
          rq.push_back({rs, model(ra, rb, rs)});
          nin++;
        end
      end
    initial begin
      int t;
      riv = 1'b0;
      rordy = 1'b1;
      ra = '0;
      rb = '0;
      rs = 1'b0;
      acc_last = 1'b0;
      fin = 1'b0;
      nin = 0;
      nout = 0;
      wait (rnd_go);
      @(posedge clk);
      #1;
      for (int c = 0; c < 400; c++) begin
        if (!riv || acc_last) begin
          riv = $urandom_range(0, 3) != 0;
          ra = pick();
          rb = pick();
          rs = 1'($urandom_range(0, 1));
        end
        rordy = $urandom_range(0, 3) != 0;
        @(negedge clk);
        acc_last = riv && rir;
        @(posedge clk);
        #1;
      end
      riv = 1'b0;
      rordy = 1'b1;
      t = 0;
      while ((rq.size() != 0 || rov) && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("rnd%0d_drain", W), 64'(t < 100), 64'(1));
      chk($sformatf("rnd%0d_count", W), 64'(nout), 64'(nin));
      chk($sformatf("rnd%0d_traffic", W), 64'(nin > 50), 64'(1));
      fin = 1'b1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, chg, t;
    logic [15:0] frozen;
    logic fs;
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h00, 8'h5A, 1'b0, 16'h0000};
    tbl[2] = '{8'h0D, 8'h0B, 1'b0, 16'h008F};
    tbl[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tbl[5] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[6] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    tbl[7] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[8] = '{8'h7F, 8'h80, 1'b0, 16'h3F80};
    rst = 1'b1;
    iv = 1'b0;
    ordy = 1'b1;
    a = '0;
    b = '0;
    s = 1'b0;
    cur_exp = '0;
    lat_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov), 64'(0));
    chk("reset_out_p", 64'(p), 64'(0));
    chk("reset_out_signed", 64'(os), 64'(0));
    chk("reset_in_ready", 64'(ir), 64'(1));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(tbl[i]);
    iv = 1'b0;
    drain();
    for (int i = 3; i < 9; i++) send(tbl[i]);
    iv = 1'b0;
    drain();
    lat_on = 1'b0;
    ordy = 1'b0;
    iv = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      a = tbl[k].a;
      b = tbl[k].b;
      s = tbl[k].s;
      cur_exp = tbl[k].p;
      @(negedge clk);
      if (ir) k++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 64'(k), 64'(3));
    chk("bp_in_ready", 64'(ir), 64'(0));
    @(negedge clk);
    frozen = p;
    fs = os;
    chg = 0;
    repeat (10) begin
      @(negedge clk);
      if (p !== frozen || os !== fs || !ov) chg++;
    end
    chk("bp_frozen_changes", 64'(chg), 64'(0));
    chk("bp_frozen_p", 64'(frozen), 64'(tbl[0].p));
    @(posedge clk);
    #1;
    ordy = 1'b1;
    #1;
    chk("release_in_ready", 64'(ir), 64'(1));
    @(posedge clk);
    #1;
    iv = 1'b0;
    drain();
    ordy = 1'b0;
    send(tbl[0]);
    send(tbl[6]);
    iv = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_out_valid", 64'(ov), 64'(1));
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(ov), 64'(0));
    chk("async_reset_out_p", 64'(p), 64'(0));
    chk("async_reset_in_ready", 64'(ir), 64'(1));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ordy = 1'b1;
    chg = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov) chg++;
    end
    chk("no_stale_after_reset", 64'(chg), 64'(0));
    @(posedge clk);
    #1;
    lat_on = 1'b1;
    iv = 1'b1;
    a = tbl[7].a;
    b = tbl[7].b;
    s = tbl[7].s;
    cur_exp = tbl[7].p;
    @(negedge clk);
    chk("post_reset_first_accept", 64'(ir), 64'(1));
    @(posedge clk);
    #1;
    iv = 1'b0;
    drain();
    rnd_go = 1'b1;
    t = 0;
    while (!(rnd[0].fin && rnd[1].fin && rnd[2].fin && rnd[3].fin) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("random_done_timeout", 64'(t < 5000), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
